// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider/remainder unit for RV32M DIV, DIVU, REM and REMU.
// One trial subtraction per cycle; fixed latency regardless of operands.
module iterative_divider #(
    parameter int unsigned BIT = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [1:0]     op_i,
    input  logic [BIT-1:0] a_i,
    input  logic [BIT-1:0] b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [BIT-1:0] result_o
);

    localparam int unsigned CNT_W = (BIT > 1) ? $clog2(BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT-1:0]     quo_q, quo_d;
    logic [BIT-1:0]     rem_q, rem_d;
    logic [BIT-1:0]     dvs_q, dvs_d;
    logic [BIT-1:0]     a_q, a_d;
    logic               op_rem_q, op_rem_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               div0_q, div0_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BIT-1:0]     result_q, result_d;

    logic               signed_op;
    logic [BIT-1:0]     a_mag, b_mag;
    logic [BIT:0]       rem_sh, diff;
    logic [BIT-1:0]     quo_fix, rem_fix;

    // State and datapath registers; async reset discards any in-flight operation
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            a_q      <= '0;
            op_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            a_q      <= a_d;
            op_rem_q <= op_rem_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Next-state: operand capture, one restoring iteration per cycle, sign fix-up and result load
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        a_d       = a_q;
        op_rem_d  = op_rem_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        result_d  = result_q;

        signed_op = ~op_i[0];
        a_mag     = (signed_op && a_i[BIT-1]) ? (~a_i + BIT'(1)) : a_i;
        b_mag     = (signed_op && b_i[BIT-1]) ? (~b_i + BIT'(1)) : b_i;
        rem_sh    = {rem_q, quo_q[BIT-1]};
        diff      = rem_sh - {1'b0, dvs_q};
        quo_fix   = neg_q_q ? (~quo_q + BIT'(1)) : quo_q;
        rem_fix   = neg_r_q ? (~rem_q + BIT'(1)) : rem_q;

        if (div0_q) begin
            quo_fix = '1;
            rem_fix = a_q;
        end else if (ovf_q) begin
            quo_fix = a_q;
            rem_fix = '0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_rem_d = op_i[1];
                    a_d      = a_i;
                    quo_d    = a_mag;
                    dvs_d    = b_mag;
                    rem_d    = '0;
                    cnt_d    = '0;
                    div0_d   = (b_i == '0);
                    ovf_d    = signed_op && (a_i == {1'b1, {(BIT-1){1'b0}}}) && (b_i == '1);
                    neg_q_d  = signed_op && (a_i[BIT-1] ^ b_i[BIT-1]) && (b_i != '0);
                    neg_r_d  = signed_op && a_i[BIT-1];
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (!diff[BIT]) begin
                    rem_d = diff[BIT-1:0];
                    quo_d = {quo_q[BIT-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[BIT-1:0];
                    quo_d = {quo_q[BIT-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIT-1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                result_d = op_rem_q ? rem_fix : quo_fix;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed self-checking bench for iterative_divider (BIT=32).
module tb_iterative_divider;

    localparam int unsigned BIT = 32;

    logic           clk_i;
    logic           rst_i;
    logic           start_i;
    logic [1:0]     op_i;
    logic [BIT-1:0] a_i;
    logic [BIT-1:0] b_i;
    logic           busy_o;
    logic           done_o;
    logic [BIT-1:0] result_o;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    iterative_divider #(.BIT(BIT)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation, optionally poking start_i at two CALC cycles, and check
    // result, done latency (edges after the sampling edge) and busy length.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int inj1, input int inj2);
        int edges;
        int busy_cnt;
        @(negedge clk_i);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        edges    = 0;
        busy_cnt = 0;
        while (!done_o && edges < 100) begin
            if (busy_o) busy_cnt++;
            if (edges == inj1 || edges == inj2) begin
                op_i    = OP_REMU;
                a_i     = 32'd77;
                b_i     = 32'd5;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            edges++;
        end
        start_i = 1'b0;
        chk({tag, " latency"}, 32'(edges), 32'(BIT + 1));
        chk({tag, " busy_len"}, 32'(busy_cnt), 32'(BIT + 1));
        chk({tag, " busy_in_done"}, {31'd0, busy_o}, 32'd0);
        chk({tag, " result"}, result_o, exp);
    endtask

    // One cycle after a done pulse with no new start: pulse gone, result held
    task automatic after_done(input string tag, input logic [31:0] exp);
        @(posedge clk_i);
        #1;
        chk({tag, " done_width"}, {31'd0, done_o}, 32'd0);
        chk({tag, " result_hold"}, result_o, exp);
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        a_i     = '0;
        b_i     = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset busy", {31'd0, busy_o}, 32'd0);
        chk("reset done", {31'd0, done_o}, 32'd0);
        chk("reset result", result_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        do_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, -1, -1);
        after_done("divu 100/7", 32'd14);
        do_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, -1, -1);
        do_op("div -100/7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, -1, -1);
        do_op("rem -100/7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, -1, -1);
        do_op("rem 100/-7", OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, -1, -1);
        do_op("div 100/-7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, -1, -1);
        do_op("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, -1, -1);
        do_op("divu x/0", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, -1, -1);
        do_op("remu x/0", OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, -1, -1);
        do_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, -1, -1);
        do_op("rem -5/0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, -1, -1);
        do_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1, -1);
        do_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, -1, -1);
        do_op("divu ovf pattern", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, -1, -1);
        after_done("divu ovf pattern", 32'd0);

        // start pokes in the middle of CALC are dropped
        do_op("ignore start", OP_DIVU, 32'd1000, 32'd10, 32'd100, 5, 20);
        after_done("ignore start", 32'd100);

        // start in the done cycle is taken immediately
        do_op("b2b first", OP_DIVU, 32'd50, 32'd6, 32'd8, -1, -1);
        do_op("b2b second", OP_REMU, 32'd50, 32'd6, 32'd2, -1, -1);
        after_done("b2b second", 32'd2);

        // asynchronous reset around CALC count 10
        @(negedge clk_i);
        op_i    = OP_DIVU;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2;
        chk("pre-reset busy", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("mid reset busy", {31'd0, busy_o}, 32'd0);
        chk("mid reset done", {31'd0, done_o}, 32'd0);
        chk("mid reset result", result_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            chk("post reset no done", {31'd0, done_o}, 32'd0);
            if (i == 39) chk("post reset idle", {31'd0, busy_o}, 32'd0);
        end
        do_op("divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
